// File: rtl/compare_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : compare_seq_ctrl
// Description : Sequential wide-operand magnitude comparator. A single 4-bit
//               cascadable compare slice is reused across the nibbles of two
//               WIDTH-bit operands. Nibbles are walked from LSB to MSB, and
//               each slice result feeds the cascade input of the next nibble.
//               The final result is a one-hot {gt, lt, eq}.
// Ports       : iClk     - clock, rising edge
//               iRst_n   - asynchronous active-low reset
//               iStart   - start request, sampled only in IDLE
//               iAbort   - synchronous abort, effective in RUN and DONE
//               iData_a  - operand A, captured on accepted start
//               iData_b  - operand B, captured on accepted start
//               oBusy    - high whenever not IDLE
//               oDone    - one-cycle pulse, oData has just been updated
//               oData    - {gt, lt, eq}; 000 until the first completion
// Revision    : 1.0 - initial release
// ============================================================================
module compare_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iStart,
    input  logic             iAbort,
    input  logic [WIDTH-1:0] iData_a,
    input  logic [WIDTH-1:0] iData_b,
    output logic             oBusy,
    output logic             oDone,
    output logic [2:0]       oData
);

    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NIB - 1);

    localparam logic [2:0] C_GT = 3'b100;
    localparam logic [2:0] C_LT = 3'b010;
    localparam logic [2:0] C_EQ = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_casc;
    logic [2:0]       r_data;

    logic [3:0]       w_na;
    logic [3:0]       w_nb;
    logic [2:0]       w_slice;

    // Nibble selection by the current count.
    always_comb begin
        w_na = 4'd0;
        w_nb = 4'd0;
        for (int i = 0; i < NIB; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_na = r_op_a[4*i +: 4];
                w_nb = r_op_b[4*i +: 4];
            end
        end
    end

    // compare_4 slice. On a nibble tie the lower-nibble verdict carries
    // forward; a malformed cascade value collapses to "equal".
    always_comb begin
        w_slice = C_EQ;
        if (w_na > w_nb) begin
            w_slice = C_GT;
        end else if (w_na < w_nb) begin
            w_slice = C_LT;
        end else begin
            case (r_casc)
                C_GT, C_LT, C_EQ: w_slice = r_casc;
                default:          w_slice = C_EQ;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= S_IDLE;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_cnt   <= '0;
            r_casc  <= C_EQ;
            r_data  <= 3'b000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        r_op_a  <= iData_a;
                        r_op_b  <= iData_b;
                        r_cnt   <= '0;
                        r_casc  <= C_EQ;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Abort wins over the final-nibble result write.
                    if (iAbort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_casc <= w_slice;
                        if (r_cnt == C_LAST) begin
                            r_data  <= w_slice;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign oBusy = (r_state != S_IDLE);
    assign oDone = (r_state == S_DONE);
    assign oData = r_data;

endmodule
`default_nettype wire
